// File: rtl/rr_mux_arb_pkg.sv
// Shared types and helpers for the round-robin N:1 mux/arbiter.
package rr_mux_arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_mux_arb_if.sv
// Handshake bundle between N producers, the mux, and one consumer.
interface rr_mux_arb_if
  import rr_mux_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int SEL_W = sel_width(N);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority grant over N requests; 0-cycle grant.
// Pointer advances only on an accepted transfer (advance), else holds.
module rr_arbiter
  import rr_mux_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int RR_EN = ARB_RR,
  parameter int SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] idx;
  logic             found;

  // Walk the channels starting at the pointer (or at 0 in fixed mode); first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      if (RR_EN == ARB_RR) idx = SEL_W'((int'(ptr_q) + k) % N);
      else                 idx = SEL_W'(k);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rr_mux_arb.sv
// N:1 valid/ready mux with arbitrated select; 1-cycle latency into a registered output.
// Backpressure: in_ready is all-zero while the output register holds data and out_ready is low.
module rr_mux_arb
  import rr_mux_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int RR_EN = ARB_RR
) (
  input logic         clk,
  input logic         rst_n,
  rr_mux_arb_if.slave bus
);

  localparam int SEL_W = sel_width(N);

  logic             load;
  logic             xfer;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] mux_dat;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;

  assign load = !out_valid_q || bus.out_ready;
  // rst_n gates the accept path so nothing is offered while reset is held.
  assign xfer = load && rst_n && (|bus.in_valid);

  if (N == 1) begin : g_single
    assign grant        = bus.in_valid;
    assign grant_idx    = '0;
    assign bus.in_ready = {N{load && rst_n}};
  end else begin : g_arb
    rr_arbiter #(
      .N     (N),
      .RR_EN (RR_EN),
      .SEL_W (SEL_W)
    ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (bus.in_valid),
      .advance   (xfer),
      .grant     (grant),
      .grant_idx (grant_idx)
    );
    assign bus.in_ready = (load && rst_n) ? grant : '0;
  end

  always_comb begin
    mux_dat = '0;
    for (int i = 0; i < N; i++) begin
      mux_dat = mux_dat | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_dat;
      out_sel_d   = grant_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised N:1 data multiplexer; successor to the 2:1 combinational mux in the combinational designs set.
- Selects among N valid/ready input channels with a round-robin arbiter (or fixed priority, by parameter) instead of an external select.
- Drives one registered valid/ready output.
- Used wherever several producers share one consumer or bus.

Parameters:
- N, 4, number of input channels (>=1)
- WIDTH, 8, data width per channel
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  N  per-channel valid
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  N  per-channel ready, at most one bit high per cycle
- out_valid  out  1  output register holds valid data
- out_data  out  WIDTH  registered selected data
- out_sel  out  SEL_W  index of the channel that supplied out_data; SEL_W = max(1, clog2(N))
- out_ready  in  1  downstream accepts out_data

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values (asynchronous on rst_n low):
  - out_valid=0, out_data=0, out_sel=0, RR pointer=0.
  - in_ready=0 while rst_n is low.
- Load enable: load = !out_valid || out_ready.
- Grant (combinational):
  - Applies when load=1 and |in_valid.
  - RR_EN=1: first valid channel searching upward from the pointer, wrapping N-1 -> 0.
  - RR_EN=0: lowest-index valid channel.
  - in_ready = one-hot(grant) when load && |in_valid, else 0.
  - in_ready never depends on the granted channel's own ready.
- Transfer: channel i is accepted when in_valid[i] && in_ready[i]. On the next edge:
  - out_data <= in_data[i], out_sel <= i, out_valid <= 1.
  - Pointer <= (i+1) mod N, with wrap from N-1 to 0.
- Output drain: out_ready=1 and no input valid -> out_valid <= 0; out_data and out_sel hold their last value.
- Latency and throughput:
  - Latency is 1 cycle from input acceptance to out_valid.
  - Full throughput: one transfer per cycle while out_ready=1.
- Output stability: while out_valid=1 && out_ready=0, out_data, out_sel and the pointer are stable, and in_ready=0.
- Pointer update: only on a transfer, never on idle cycles. Unused when RR_EN=0.
- Fairness (RR_EN=1): a continuously valid channel is granted within N transfers.
- Input rule: upstream must not drop in_valid or change in_data before acceptance. The block does not check this.
- Simultaneous output accept and new grant in the same cycle: the register reloads with no bubble.
- N=1: in_ready[0] = load, out_sel=0 constant, no arbitration logic.
- Reset mid-operation: the held output is discarded, out_valid goes low immediately, and the pointer returns to 0. After release, the first grant goes to the lowest valid index.

Decomposition:
- Shared package:
  - sel_width function: max(1, clog2(n)).
  - arbitration mode constants: ARB_RR=1, ARB_FIXED=0.
- Sub-module rr_arbiter(N, RR_EN):
  - Holds the pointer register and the rotate / priority-encode / unrotate logic.
  - Inputs: req[N], advance.
  - Outputs: grant one-hot[N], grant_idx[SEL_W].
- Top level: load logic, data mux (AND-OR over the one-hot grant) and output register.

Test Plan:
- Reset: rst_n=0, in_valid=4'b1111, out_ready=1 -> in_ready=0000, out_valid=0, out_data=0x00, out_sel=0. Release rst_n -> first grant is ch0.
- Single channel: in_valid=4'b0100, in_data ch2=0xA5, out_ready=1 -> in_ready=4'b0100 the same cycle. Next cycle out_valid=1, out_data=0xA5, out_sel=2. Then in_valid=0 -> out_valid=0 one cycle later.
- Round-robin fairness: N=4, all valid, ch i data=0x10+i, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles, data 0x10..0x13, no bubbles.
- Backpressure: out_valid=1 (out_sel=1, 0x11), out_ready=0 for 5 cycles -> outputs stable, in_ready=0000. Raise out_ready -> next out_sel=2 on the following cycle.
- Fixed priority: RR_EN=0, all valid, out_ready=1 -> out_sel=0 every cycle. Drop ch0 valid -> out_sel=1.
- Reset mid-operation: out_valid=1, out_ready=0, pointer=3, then pulse rst_n low between edges -> out_valid=0 immediately. After release with all valid, first out_sel=0.
